// File: rtl/signal_period_meter_pkg.sv
// Shared definitions for the signal period meter.
// - meter_state_t : FSM state encoding (IDLE=0, ARM=1, HIGH=2, LOW=3, HOLD=4)
// - DEF_CNT_W / DEF_SYNC_STAGES : default parameter values
package signal_period_meter_pkg;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    HIGH = 3'd2,
    LOW  = 3'd3,
    HOLD = 3'd4
  } meter_state_t;

endpackage

// File: rtl/signal_period_meter_sync_edge_detect.sv
// Synchroniser plus edge detector for the asynchronous measured waveform.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   sig_in     : asynchronous input waveform
//   sig_s      : sig_in delayed by SYNC_STAGES clocks
//   rise/fall  : one-cycle pulses when sig_s changes 0->1 / 1->0
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d;
  assign fall  = ~sig_s & sig_d;

endmodule

// File: rtl/signal_period_meter.sv
// Measures high-phase, low-phase and period length (in clk cycles) of a
// 1-bit square wave and presents the result on a valid/ready output.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   sig_in           : waveform under measurement (asynchronous)
//   enable           : 1 = arm and measure, 0 = abort to IDLE (ignored in HOLD)
//   meas_ready       : consumer ready
//   meas_valid       : result valid (HOLD state)
//   high_cnt/low_cnt : phase lengths, saturating at 2^CNT_W-1
//   period_cnt       : high_cnt + low_cnt, CNT_W+1 bits
//   overflow         : a phase counter saturated in this measurement
//   busy             : state is ARM, HIGH or LOW
//   dbg_state        : current FSM state
// Handshake: a result is transferred on every posedge where meas_valid and
// meas_ready are both 1; while meas_valid=1 and meas_ready=0 the result and
// meas_valid stay unchanged.
module signal_period_meter
  import signal_period_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic             overflow,
  output logic             busy,
  output meter_state_t     dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic sig_s, rise, fall;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .sig_s  (sig_s),
    .rise   (rise),
    .fall   (fall)
  );

  meter_state_t     state, state_nxt;
  logic [CNT_W-1:0] hcnt, hcnt_nxt, lcnt, lcnt_nxt;
  logic [CNT_W-1:0] hcnt_inc, lcnt_inc;
  logic             load_res, res_ovf;
  logic [CNT_W-1:0] res_high, res_low;

  assign hcnt_inc = hcnt + 1'b1;
  assign lcnt_inc = lcnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      hcnt       <= '0;
      lcnt       <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period_cnt <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      lcnt  <= lcnt_nxt;
      // Results load on the same edge that enters HOLD, so data and
      // meas_valid appear together.
      if (load_res) begin
        high_cnt   <= res_high;
        low_cnt    <= res_low;
        period_cnt <= {1'b0, res_high} + {1'b0, res_low};
        overflow   <= res_ovf;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    lcnt_nxt  = lcnt;
    load_res  = 1'b0;
    res_high  = hcnt;
    res_low   = lcnt;
    res_ovf   = 1'b0;
    case (state)
      IDLE: begin
        hcnt_nxt = '0;
        lcnt_nxt = '0;
        if (enable) state_nxt = ARM;
      end
      ARM: begin
        // Abort takes priority over a rise in the same cycle.
        if (!enable) begin
          state_nxt = IDLE;
          hcnt_nxt  = '0;
          lcnt_nxt  = '0;
        end else if (rise) begin
          state_nxt = HIGH;
          hcnt_nxt  = {{(CNT_W-1){1'b0}}, 1'b1};
          lcnt_nxt  = '0;
        end
      end
      HIGH: begin
        if (!enable) begin
          state_nxt = IDLE;
          hcnt_nxt  = '0;
          lcnt_nxt  = '0;
        end else if (fall) begin
          state_nxt = LOW;
          lcnt_nxt  = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (sig_s) begin
          hcnt_nxt = hcnt_inc;
          // Saturated high phase: stuck or too-slow input.
          if (hcnt_inc == CNT_MAX) begin
            state_nxt = HOLD;
            load_res  = 1'b1;
            res_high  = CNT_MAX;
            res_low   = '0;
            res_ovf   = 1'b1;
          end
        end
      end
      LOW: begin
        if (!enable) begin
          state_nxt = IDLE;
          hcnt_nxt  = '0;
          lcnt_nxt  = '0;
        end else if (rise) begin
          state_nxt = HOLD;
          load_res  = 1'b1;
        end else if (!sig_s) begin
          lcnt_nxt = lcnt_inc;
          if (lcnt_inc == CNT_MAX) begin
            state_nxt = HOLD;
            load_res  = 1'b1;
            res_low   = CNT_MAX;
            res_ovf   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (meas_ready) begin
          state_nxt = enable ? ARM : IDLE;
          hcnt_nxt  = '0;
          lcnt_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign meas_valid = (state == HOLD);
  assign busy       = (state == ARM) || (state == HIGH) || (state == LOW);
  assign dbg_state  = state;

endmodule

// File: tb/tb_signal_period_meter.sv
module tb_signal_period_meter;
  import signal_period_meter_pkg::*;

  localparam int W = 33; // {ovf, high[15:0], low[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic rst_n = 1'b0;
  logic enable = 1'b0, meas_ready = 1'b0;
  logic enable4 = 1'b0, ready4 = 1'b0;
  logic gen_on = 1'b0, gen_sig = 1'b0, man_sig = 1'b0;
  logic sig_in;
  assign sig_in = gen_on ? gen_sig : man_sig;

  // 16-bit instance
  logic         meas_valid, overflow, busy;
  logic [15:0]  high_cnt, low_cnt;
  logic [16:0]  period_cnt;
  meter_state_t dbg_state;

  signal_period_meter dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
    .meas_ready(meas_ready), .meas_valid(meas_valid), .high_cnt(high_cnt),
    .low_cnt(low_cnt), .period_cnt(period_cnt), .overflow(overflow),
    .busy(busy), .dbg_state(dbg_state)
  );

  // 4-bit instance for saturation cases
  logic         valid4, ovf4, busy4;
  logic [3:0]   high4, low4;
  logic [4:0]   period4;
  meter_state_t state4;

  signal_period_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable4),
    .meas_ready(ready4), .meas_valid(valid4), .high_cnt(high4),
    .low_cnt(low4), .period_cnt(period4), .overflow(ovf4),
    .busy(busy4), .dbg_state(state4)
  );

  // ---------------- square-wave generator ----------------
  int hi_len = 5, lo_len = 5, ph_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!gen_on) begin
        gen_sig = 1'b0;
        ph_cnt  = 0;
      end else begin
        ph_cnt++;
        if (gen_sig && ph_cnt >= hi_len) begin
          gen_sig = 1'b0;
          ph_cnt  = 0;
        end else if (!gen_sig && ph_cnt >= lo_len) begin
          gen_sig = 1'b1;
          ph_cnt  = 0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_fail = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int h, input int l, input bit o);
    exp_q.push_back({o, 16'(h), 16'(l)});
  endtask

  task automatic check_res(input string tag, input bit sel4);
    logic [W-1:0] e;
    logic [31:0]  eh, el;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
      return;
    end
    e  = exp_q.pop_front();
    eh = 32'(e[31:16]);
    el = 32'(e[15:0]);
    if (sel4) begin
      check({tag, "_high"},   32'(high4),   eh);
      check({tag, "_low"},    32'(low4),    el);
      check({tag, "_period"}, 32'(period4), eh + el);
      check({tag, "_ovf"},    32'(ovf4),    32'(e[32]));
    end else begin
      check({tag, "_high"},   32'(high_cnt),   eh);
      check({tag, "_low"},    32'(low_cnt),    el);
      check({tag, "_period"}, 32'(period_cnt), eh + el);
      check({tag, "_ovf"},    32'(overflow),   32'(e[32]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input bit sel4, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((sel4 ? valid4 : meas_valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_state(input string tag, input meter_state_t st, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dbg_state == st) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_sig(input string tag, input logic lvl, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sig_in == lvl) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic set_pattern(input int h, input int l);
    gen_on = 1'b0;
    tick(3);
    hi_len = h;
    lo_len = l;
    gen_on = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit seen;
    int lat;

    // Reset state
    tick(3);
    check("rst_valid",  32'(meas_valid), 0);
    check("rst_high",   32'(high_cnt),   0);
    check("rst_low",    32'(low_cnt),    0);
    check("rst_period", 32'(period_cnt), 0);
    check("rst_ovf",    32'(overflow),   0);
    check("rst_busy",   32'(busy),       0);
    rst_n = 1'b1;
    tick(2);

    // 1: symmetric 5/5, ready held high
    meas_ready = 1'b1;
    set_pattern(5, 5);
    enable = 1'b1;
    push_exp(5, 5, 1'b0);
    wait_valid("t1a", 1'b0, 60);
    check_res("t1a", 1'b0);
    tick(1);
    check("t1_valid_drop", 32'(meas_valid), 0);
    push_exp(5, 5, 1'b0);
    wait_valid("t1b", 1'b0, 60);
    check_res("t1b", 1'b0);

    // 2: 3 high / 7 low
    enable = 1'b0;
    tick(2);
    set_pattern(3, 7);
    enable = 1'b1;
    push_exp(3, 7, 1'b0);
    wait_valid("t2", 1'b0, 60);
    check_res("t2", 1'b0);

    // 4: backpressure during HOLD, edges and enable ignored
    tick(1);
    meas_ready = 1'b0;
    push_exp(3, 7, 1'b0);
    wait_valid("t4a", 1'b0, 60);
    check_res("t4a", 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      enable = (i >= 10 && i < 15) ? 1'b0 : 1'b1;
      tick(1);
      if (meas_valid !== 1'b1 || high_cnt !== 16'd3 || low_cnt !== 16'd7 ||
          period_cnt !== 17'd10)
        seen = 1'b1;
    end
    check("t4_hold_stable", 32'(seen), 0);
    meas_ready = 1'b1;
    tick(1);
    check("t4_valid_drop", 32'(meas_valid), 0);
    push_exp(3, 7, 1'b0);
    wait_valid("t4b", 1'b0, 60);
    check_res("t4b", 1'b0);

    // 5: reset while in HIGH
    enable = 1'b0;
    tick(2);
    set_pattern(5, 5);
    enable = 1'b1;
    wait_state("t5_high", HIGH, 60);
    rst_n  = 1'b0;
    enable = 1'b0;
    tick(1);
    check("t5_valid",  32'(meas_valid), 0);
    check("t5_high",   32'(high_cnt),   0);
    check("t5_low",    32'(low_cnt),    0);
    check("t5_period", 32'(period_cnt), 0);
    check("t5_ovf",    32'(overflow),   0);
    check("t5_busy",   32'(busy),       0);
    check("t5_state",  32'(dbg_state),  32'(IDLE));
    rst_n = 1'b1;
    wait_sig("t5_low_phase", 1'b0, 30);
    tick(3);
    enable = 1'b1;
    push_exp(5, 5, 1'b0);
    wait_valid("t5", 1'b0, 60);
    check_res("t5", 1'b0);

    // 6: abort in LOW, re-enable mid high phase
    enable = 1'b0;
    tick(2);
    set_pattern(4, 6);
    enable = 1'b1;
    wait_state("t6_low", LOW, 60);
    enable = 1'b0;
    tick(1);
    check("t6_state", 32'(dbg_state), 32'(IDLE));
    check("t6_busy",  32'(busy),      0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (meas_valid !== 1'b0) seen = 1'b1;
    end
    check("t6_no_valid", 32'(seen), 0);
    wait_sig("t6_sig_high", 1'b1, 30);
    tick(3);
    enable = 1'b1;
    push_exp(4, 6, 1'b0);
    wait_valid("t6", 1'b0, 60);
    check_res("t6", 1'b0);

    // 3: 4-bit saturation on the second instance
    enable  = 1'b0;
    gen_on  = 1'b0;
    man_sig = 1'b0;
    tick(4);
    enable4 = 1'b1;
    tick(2);
    check("t3_busy", 32'(busy4), 1);
    man_sig = 1'b1;
    push_exp(15, 0, 1'b1);
    wait_valid("t3a", 1'b1, 40);
    check_res("t3a", 1'b1);
    tick(5);
    check("t3_hold", 32'(valid4), 1);
    ready4 = 1'b1;
    tick(1);
    ready4 = 1'b0;
    check("t3_valid_drop", 32'(valid4), 0);
    // low phase saturates: 2 high, then stuck low
    man_sig = 1'b0;
    tick(4);
    man_sig = 1'b1;
    tick(2);
    man_sig = 1'b0;
    push_exp(2, 15, 1'b1);
    wait_valid("t3b", 1'b1, 40);
    check_res("t3b", 1'b1);
    ready4 = 1'b1;
    tick(1);
    ready4 = 1'b0;
    // latency from ending sig_in rise to valid is SYNC_STAGES+1
    man_sig = 1'b1;
    tick(3);
    man_sig = 1'b0;
    tick(4);
    man_sig = 1'b1;
    lat = 0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      if (valid4 === 1'b1 && lat == 0) lat = k;
    end
    check("t3_latency", 32'(lat), 3);
    push_exp(3, 4, 1'b0);
    check_res("t3c", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
